// File: rtl/streebog_msg_pad.sv
`default_nettype none
// ==========================================================================
// Module   : streebog_msg_pad
// Function : 64-bit word stream to 512-bit Streebog blocks with GOST padding
// Revision : 1.0
// ==========================================================================
module streebog_msg_pad #(
  parameter int WORD_W = 64,
  parameter int BLK_W  = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  input  logic [3:0]        in_nbytes,
  output logic              blk_valid,
  input  logic              blk_ready,
  output logic [BLK_W-1:0]  blk_data,
  output logic [9:0]        blk_nbits,
  output logic              blk_last
);

  typedef enum logic [1:0] {
    S_FILL     = 2'd0,
    S_EMIT     = 2'd1,
    S_EMIT_PAD = 2'd2
  } state_t;

  localparam logic [BLK_W-1:0] C_PAD_BLK  = {{(BLK_W-1){1'b0}}, 1'b1};
  localparam logic [9:0]       C_FULL_BIT = 10'd512;

  state_t              r_state;
  logic [BLK_W-1:0]    r_buf;
  logic [2:0]          r_widx;
  logic [6:0]          r_bcnt;
  logic                r_pad_pending;
  logic [9:0]          r_nbits;
  logic                r_last;

  state_t              w_state_nxt;
  logic [BLK_W-1:0]    w_buf_nxt;
  logic [2:0]          w_widx_nxt;
  logic [6:0]          w_bcnt_nxt;
  logic                w_pad_nxt;
  logic [9:0]          w_nbits_nxt;
  logic                w_last_nxt;

  logic [3:0]          w_nb;
  logic [WORD_W-1:0]   w_word;
  logic [6:0]          w_bcnt_sum;
  logic                w_in_hs;
  logic                w_blk_hs;

  assign in_ready  = (r_state == S_FILL) & ~rst;
  assign blk_valid = (r_state != S_FILL);
  assign blk_data  = r_buf;
  assign blk_nbits = r_nbits;
  assign blk_last  = r_last;

  assign w_in_hs  = in_valid & in_ready;
  assign w_blk_hs = blk_valid & blk_ready;

  // Byte count of this word: always 8 unless it closes the message.
  always_comb begin
    w_nb = 4'd8;
    if (in_last && (in_nbytes < 4'd8)) begin
      w_nb = in_nbytes;
    end
  end

  assign w_bcnt_sum = r_bcnt + {3'b000, w_nb};

  genvar k;
  generate
    for (k = 0; k < 8; k++) begin : g_mask
      assign w_word[8*k +: 8] = (w_nb > 4'(k)) ? in_data[8*k +: 8] : 8'h00;
    end
  endgenerate

  always_comb begin
    w_state_nxt = r_state;
    w_buf_nxt   = r_buf;
    w_widx_nxt  = r_widx;
    w_bcnt_nxt  = r_bcnt;
    w_pad_nxt   = r_pad_pending;
    w_nbits_nxt = r_nbits;
    w_last_nxt  = r_last;
    case (r_state)
      S_FILL: begin
        if (w_in_hs) begin
          w_buf_nxt[{r_widx, 6'b000000} +: WORD_W] = w_word;
          w_bcnt_nxt = w_bcnt_sum;
          w_widx_nxt = r_widx + 3'd1;
          if (in_last) begin
            w_state_nxt = S_EMIT;
            if (w_bcnt_sum[6]) begin
              // Exactly 64 bytes: the marker needs a block of its own.
              w_nbits_nxt = C_FULL_BIT;
              w_last_nxt  = 1'b0;
              w_pad_nxt   = 1'b1;
            end else begin
              w_buf_nxt[{w_bcnt_sum[5:0], 3'b000} +: 8] = 8'h01;
              w_nbits_nxt = {w_bcnt_sum, 3'b000};
              w_last_nxt  = 1'b1;
            end
          end else if (r_widx == 3'd7) begin
            w_state_nxt = S_EMIT;
            w_nbits_nxt = C_FULL_BIT;
            w_last_nxt  = 1'b0;
          end
        end
      end
      S_EMIT: begin
        if (w_blk_hs) begin
          if (r_pad_pending) begin
            w_state_nxt = S_EMIT_PAD;
            w_pad_nxt   = 1'b0;
            w_buf_nxt   = C_PAD_BLK;
            w_nbits_nxt = 10'd0;
            w_last_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_FILL;
            w_buf_nxt   = '0;
            w_widx_nxt  = 3'd0;
            w_bcnt_nxt  = 7'd0;
            w_nbits_nxt = 10'd0;
            w_last_nxt  = 1'b0;
          end
        end
      end
      S_EMIT_PAD: begin
        if (w_blk_hs) begin
          w_state_nxt = S_FILL;
          w_buf_nxt   = '0;
          w_widx_nxt  = 3'd0;
          w_bcnt_nxt  = 7'd0;
          w_nbits_nxt = 10'd0;
          w_last_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_FILL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_FILL;
      r_buf         <= '0;
      r_widx        <= 3'd0;
      r_bcnt        <= 7'd0;
      r_pad_pending <= 1'b0;
      r_nbits       <= 10'd0;
      r_last        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_buf         <= w_buf_nxt;
      r_widx        <= w_widx_nxt;
      r_bcnt        <= w_bcnt_nxt;
      r_pad_pending <= w_pad_nxt;
      r_nbits       <= w_nbits_nxt;
      r_last        <= w_last_nxt;
    end
  end

endmodule
`default_nettype wire
